// File: rtl/wptr_ctrl_lvl.sv
// wptr_ctrl_lvl: async-FIFO write-side pointer control with full, almost-full, fill level and sticky overflow.
module wptr_ctrl_lvl #(
    parameter int ADDR_W = 3,
    parameter int PTR_W  = ADDR_W + 1
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              w_en,
    input  logic [PTR_W-1:0]  g_rptr_sync,
    input  logic [PTR_W-1:0]  af_thresh,
    input  logic              ovf_clr,
    output logic              wr_fire,
    output logic [ADDR_W-1:0] waddr,
    output logic [PTR_W-1:0]  b_wptr,
    output logic [PTR_W-1:0]  g_wptr,
    output logic              full,
    output logic              almost_full,
    output logic [PTR_W-1:0]  wlevel,
    output logic              overflow
);
    logic [PTR_W-1:0] b_rptr_sync, b_wptr_next, g_wptr_next, level_next;
    logic             full_next;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        b_rptr_sync = '0;
        for (int i = 0; i < PTR_W; i++)
            b_rptr_sync[i] = ^(g_rptr_sync >> i);
    end
    assign wr_fire     = w_en & ~full;
    assign waddr       = b_wptr[ADDR_W-1:0];
    assign b_wptr_next = b_wptr + PTR_W'(wr_fire);
    assign g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);
    assign level_next  = b_wptr_next - b_rptr_sync;
    // Full when write pointer equals read pointer with the top two Gray bits inverted
    assign full_next   = g_wptr_next == (g_rptr_sync ^ {2'b11, {(PTR_W-2){1'b0}}});
    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_wptr_next;
            g_wptr      <= g_wptr_next;
            full        <= full_next;
            almost_full <= level_next >= af_thresh;
            wlevel      <= level_next;
            overflow    <= (w_en & full) | (overflow & ~ovf_clr);
        end
    end
endmodule

// File: doc/wptr_ctrl_lvl.md
Name: wptr_ctrl_lvl

Overview:
- Parametrised successor to the async-FIFO write-side pointer handler. Runs in the write clock domain and receives the read pointer already synchronised as Gray code.
- Produces the binary and Gray write pointers, the RAM write address and a write strobe.
- Also produces registered full, programmable almost-full, a fill-level count and a sticky overflow flag.
- Depth is generalised to 2^ADDR_W entries.

Parameters:
- ADDR_W, 3, RAM address width; depth = 2^ADDR_W; legal range 2..12.
- PTR_W, ADDR_W+1, pointer width (includes the wrap bit); derived, must not be overridden.

Ports:
- wclk  input  1  write-domain clock; all state changes on its rising edge.
- wrst  input  1  reset; one clock; reset is synchronous and active-high.
- w_en  input  1  write request from the producer.
- g_rptr_sync  input  PTR_W  read pointer, Gray code, already synchronised into wclk.
- af_thresh  input  PTR_W  almost-full threshold, in entries (0..2^ADDR_W).
- ovf_clr  input  1  clears the sticky overflow flag.
- wr_fire  output  1  combinational; w_en & ~full; RAM write enable.
- waddr  output  ADDR_W  b_wptr[ADDR_W-1:0]; RAM write address.
- b_wptr  output  PTR_W  binary write pointer (registered).
- g_wptr  output  PTR_W  Gray write pointer (registered), sent to the read domain.
- full  output  1  registered full flag.
- almost_full  output  1  registered; level >= af_thresh.
- wlevel  output  PTR_W  registered fill level, 0..2^ADDR_W.
- overflow  output  1  sticky; a write was attempted while full.

Behaviour:
- Reset (wrst=1 at a wclk edge):
  - b_wptr, g_wptr, wlevel = 0; full, almost_full, overflow = 0.
  - Reset overrides every other input, including w_en and ovf_clr.
  - Reset asserted mid-burst discards pointer state with no partial update.
- Reset while wrst=1: full=0 forces wr_fire=w_en. The producer must hold w_en low during reset.
- Read-pointer conversion (combinational):
  - b_rptr_sync[PTR_W-1] = g_rptr_sync[PTR_W-1].
  - b_rptr_sync[i] = b_rptr_sync[i+1] ^ g_rptr_sync[i], for i descending.
- Next-state logic:
  - b_wptr_next = b_wptr + wr_fire, modulo 2^PTR_W; wraps from 2^PTR_W-1 to 0.
  - g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1).
- Each wclk edge loads b_wptr <= b_wptr_next and g_wptr <= g_wptr_next. Write-side latency is 1 cycle.
- Full:
  - full <= (g_wptr_next == {~g_rptr_sync[PTR_W-1:PTR_W-2], g_rptr_sync[PTR_W-3:0]}).
  - Full therefore asserts on the same edge that stores the last free entry.
- Level: wlevel <= (b_wptr_next - b_rptr_sync) modulo 2^PTR_W. Always consistent with full, so full=1 iff wlevel == 2^ADDR_W.
- Almost full: almost_full <= (level_next >= af_thresh), an unsigned compare.
  - af_thresh=0 gives almost_full=1 from the first edge after reset.
  - af_thresh > 2^ADDR_W means almost_full never asserts.
- Read-side movement:
  - A change on g_rptr_sync is reflected in full, wlevel and almost_full at the next wclk edge.
  - A write and a read-pointer advance in the same cycle both count; net level is unchanged.
- Overflow:
  - A write attempt while full (w_en=1, full=1) sets overflow at the next edge. The write is dropped: pointers hold and waddr is unchanged.
  - ovf_clr=1 clears overflow at the next edge.
  - Simultaneous set and clear: set wins, and overflow stays 1.
- Gray monotonicity: g_wptr changes by at most 1 bit per edge, including at pointer wrap.

Test Plan:
- Reset: hold wrst=1 for 2 edges with w_en=0 and a random g_rptr_sync -> all registered outputs 0, waddr=0, wr_fire=0.
- Fill (ADDR_W=3, g_rptr_sync=0, af_thresh=6, w_en=1 for 8 edges):
  - almost_full rises on edge 6, with wlevel=6.
  - full rises on edge 8, with b_wptr=4'b1000, g_wptr=4'b1100, wlevel=8.
  - wr_fire is 1 on all 8 cycles.
- Overflow: continue from Fill with w_en=1 for 2 more edges -> wr_fire=0, b_wptr stays 8, overflow=1.
  - Then pulse ovf_clr=1 with w_en=1 -> overflow stays 1.
  - Then ovf_clr=1 with w_en=0 -> overflow=0.
- Drain release: from full (b_wptr=8), drive g_rptr_sync=4'b0110 (binary 4) with w_en=0 -> after 1 edge full=0, wlevel=4, almost_full=0.
- Simultaneous write and read: wlevel=4, w_en=1, rptr advancing 4->5 (Gray 0110->0111) in the same cycle -> wlevel stays 4, b_wptr increments by 1.
- Wrap: preset b_wptr=15 by writing with the rptr tracking behind it, then write -> b_wptr=0, g_wptr=0, waddr=0.
  - Check g_wptr Hamming distance is 1 on every edge.
  - Check full/wlevel stay correct across the wrap.
